alu_rs_scheduler: RTL and testbench

//  ALU reservation station and issue scheduler between the Decoder and the ALU.

---
 rtl/alu_rs_scheduler.sv | 157 +++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - ALU reservation station with CDB wakeup and single-issue scheduler
// Build option ALU_RS_OLDEST_FIRST_EN: issue the oldest ready entry instead of the lowest-index one.
module alu_rs_scheduler #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_write,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_q1_busy,
  input  logic [TAG_W-1:0]  in_q1_tag,
  input  logic [DATA_W-1:0] in_v1,
  input  logic              in_q2_busy,
  input  logic [TAG_W-1:0]  in_q2_tag,
  input  logic [DATA_W-1:0] in_v2,
  input  logic [TAG_W-1:0]  in_dest,
  output logic              alu_stall,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [TAG_W-1:0]  out_dest
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int RANK_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q, b1_q, b2_q;
  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [TAG_W-1:0]  t1_q   [DEPTH];
  logic [TAG_W-1:0]  t2_q   [DEPTH];
  logic [DATA_W-1:0] v1_q   [DEPTH];
  logic [DATA_W-1:0] v2_q   [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];

  logic              out_valid_q;
  logic [OP_W-1:0]   out_op_q;
  logic [DATA_W-1:0] out_a_q, out_b_q;
  logic [TAG_W-1:0]  out_dest_q;

  logic [DEPTH-1:0]  ready;
  logic [IDX_W-1:0]  free_idx, sel_idx;
  logic              issue_en, do_issue, accept;
  logic              in_hit1, in_hit2;

  assign alu_stall = &valid_q;
  assign ready     = valid_q & ~b1_q & ~b2_q;
  assign issue_en  = ~out_valid_q | out_ready;
  assign do_issue  = issue_en & (|ready);
  assign accept    = alu_write & ~alu_stall;
  // Bypass so a broadcast coinciding with the write is not lost.
  assign in_hit1   = in_q1_busy & cdb_valid & (in_q1_tag == cdb_tag);
  assign in_hit2   = in_q2_busy & cdb_valid & (in_q2_tag == cdb_tag);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef ALU_RS_OLDEST_FIRST_EN
  // Rank 0 is the oldest live entry; ranks stay dense as entries leave.
  logic [RANK_W-1:0] rank_q [DEPTH];
  logic [RANK_W-1:0] valid_cnt, new_rank;
  logic              sel_found;

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    valid_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!sel_found || rank_q[i] < rank_q[sel_idx])) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
      valid_cnt = valid_cnt + RANK_W'(valid_q[i]);
    end
    new_rank = valid_cnt - RANK_W'(do_issue);
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q     <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_dest_q  <= '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
      for (int i = 0; i < DEPTH; i++) rank_q[i] <= '0;
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && b1_q[i] && cdb_valid && t1_q[i] == cdb_tag) begin
          v1_q[i] <= cdb_data;
          b1_q[i] <= 1'b0;
        end
        if (valid_q[i] && b2_q[i] && cdb_valid && t2_q[i] == cdb_tag) begin
          v2_q[i] <= cdb_data;
          b2_q[i] <= 1'b0;
        end
`ifdef ALU_RS_OLDEST_FIRST_EN
        if (do_issue && valid_q[i] && rank_q[i] > rank_q[sel_idx])
          rank_q[i] <= rank_q[i] - RANK_W'(1);
`endif
      end

      if (do_issue) begin
        out_valid_q      <= 1'b1;
        out_op_q         <= op_q[sel_idx];
        out_a_q          <= v1_q[sel_idx];
        out_b_q          <= v2_q[sel_idx];
        out_dest_q       <= dest_q[sel_idx];
        valid_q[sel_idx] <= 1'b0;
      end else if (issue_en) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        valid_q[free_idx] <= 1'b1;
        op_q[free_idx]    <= in_op;
        b1_q[free_idx]    <= in_q1_busy & ~in_hit1;
        t1_q[free_idx]    <= in_q1_tag;
        v1_q[free_idx]    <= in_hit1 ? cdb_data : in_v1;
        b2_q[free_idx]    <= in_q2_busy & ~in_hit2;
        t2_q[free_idx]    <= in_q2_tag;
        v2_q[free_idx]    <= in_hit2 ? cdb_data : in_v2;
        dest_q[free_idx]  <= in_dest;
`ifdef ALU_RS_OLDEST_FIRST_EN
        rank_q[free_idx]  <= new_rank;
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_dest  = out_dest_q;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb/tb_alu_rs_scheduler.sv - self-checking bench for alu_rs_scheduler
// Honors ALU_RS_OLDEST_FIRST_EN to pick the expected issue policy.
module tb_alu_rs_scheduler;
  localparam int DEPTH = 4;
`ifdef ALU_RS_OLDEST_FIRST_EN
  localparam bit OLDEST = 1'b1;
`else
  localparam bit OLDEST = 1'b0;
`endif

  logic        clk, rst, flush, alu_write, alu_stall;
  logic [3:0]  in_op, out_op;
  logic        in_q1_busy, in_q2_busy;
  logic [2:0]  in_q1_tag, in_q2_tag, in_dest, cdb_tag, out_dest;
  logic [31:0] in_v1, in_v2, cdb_data, out_a, out_b;
  logic        cdb_valid, out_valid, out_ready;

  alu_rs_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush), .alu_write(alu_write), .in_op(in_op),
    .in_q1_busy(in_q1_busy), .in_q1_tag(in_q1_tag), .in_v1(in_v1),
    .in_q2_busy(in_q2_busy), .in_q2_tag(in_q2_tag), .in_v2(in_v2),
    .in_dest(in_dest), .alu_stall(alu_stall), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_a(out_a), .out_b(out_b),
    .out_dest(out_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush = 0; alu_write = 0; in_op = 0;
    in_q1_busy = 0; in_q1_tag = 0; in_v1 = 0;
    in_q2_busy = 0; in_q2_tag = 0; in_v2 = 0; in_dest = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic wr(input logic [3:0] op, input logic b1, input logic [2:0] t1,
                    input logic [31:0] v1, input logic [31:0] v2, input logic [2:0] dest);
    alu_write = 1; in_op = op; in_q1_busy = b1; in_q1_tag = t1; in_v1 = v1;
    in_q2_busy = 0; in_q2_tag = 0; in_v2 = v2; in_dest = dest;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
    cdb_valid = 1; cdb_tag = tag; cdb_data = data;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic chk_out(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] dest);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_op"}, out_op, op);
    chk({name, "_a"}, out_a, a);
    chk({name, "_b"}, out_b, b);
    chk({name, "_dest"}, out_dest, dest);
  endtask

  // Directed cycle table: inputs for the cycle and outputs expected before its edge.
  typedef struct {
    logic rst, wr, b1; logic [2:0] t1; logic [31:0] v1, v2; logic [2:0] dest;
    logic cv; logic [2:0] ct; logic [31:0] cd; logic rdy; logic chk;
    logic e_stall, e_ov; logic [31:0] e_a, e_b; logic [2:0] e_dest;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mkv(input logic r, input logic w, input logic b1, input logic [2:0] t1,
      input logic [31:0] v1, input logic [31:0] v2, input logic [2:0] dest, input logic cv,
      input logic [2:0] ct, input logic [31:0] cd, input logic rdy, input logic c,
      input logic es, input logic eov, input logic [31:0] ea, input logic [31:0] eb,
      input logic [2:0] ed);
    vec_t v;
    v.rst = r; v.wr = w; v.b1 = b1; v.t1 = t1; v.v1 = v1; v.v2 = v2; v.dest = dest;
    v.cv = cv; v.ct = ct; v.cd = cd; v.rdy = rdy; v.chk = c;
    v.e_stall = es; v.e_ov = eov; v.e_a = ea; v.e_b = eb; v.e_dest = ed;
    return v;
  endfunction

  // Reference model: slots tagged with an allocation sequence number.
  typedef struct {
    logic v; logic [3:0] op; logic b1; logic [2:0] t1; logic [31:0] v1;
    logic b2; logic [2:0] t2; logic [31:0] v2; logic [2:0] dest; int seq;
  } slot_t;
  slot_t m_slot[DEPTH];
  logic m_ov; logic [3:0] m_op; logic [31:0] m_a, m_b; logic [2:0] m_dest;
  int m_seq = 0;

  function automatic logic m_full();
    for (int i = 0; i < DEPTH; i++) if (!m_slot[i].v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    slot_t nxt[DEPTH];
    int best, fr;
    logic full;
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) m_slot[i].v = 0;
      m_ov = 0; m_op = 0; m_a = 0; m_b = 0; m_dest = 0;
      return;
    end
    nxt = m_slot;
    full = m_full();
    best = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_slot[i].v && !m_slot[i].b1 && !m_slot[i].b2)
        if (best < 0 || (OLDEST && m_slot[i].seq < m_slot[best].seq)) best = i;
    if (!m_ov || out_ready) begin
      if (best >= 0) begin
        m_ov = 1; m_op = m_slot[best].op; m_a = m_slot[best].v1;
        m_b = m_slot[best].v2; m_dest = m_slot[best].dest;
        nxt[best].v = 0;
      end else m_ov = 0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (nxt[i].v && cdb_valid && nxt[i].b1 && nxt[i].t1 == cdb_tag) begin
        nxt[i].b1 = 0; nxt[i].v1 = cdb_data;
      end
      if (nxt[i].v && cdb_valid && nxt[i].b2 && nxt[i].t2 == cdb_tag) begin
        nxt[i].b2 = 0; nxt[i].v2 = cdb_data;
      end
    end
    if (alu_write && !full) begin
      fr = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_slot[i].v) fr = i;
      nxt[fr].v = 1; nxt[fr].op = in_op; nxt[fr].dest = in_dest; nxt[fr].seq = m_seq++;
      nxt[fr].t1 = in_q1_tag; nxt[fr].t2 = in_q2_tag;
      nxt[fr].b1 = in_q1_busy && !(cdb_valid && cdb_tag == in_q1_tag);
      nxt[fr].v1 = (in_q1_busy && !nxt[fr].b1) ? cdb_data : in_v1;
      nxt[fr].b2 = in_q2_busy && !(cdb_valid && cdb_tag == in_q2_tag);
      nxt[fr].v2 = (in_q2_busy && !nxt[fr].b2) ? cdb_data : in_v2;
    end
    m_slot = nxt;
  endtask

  initial begin
    logic [2:0] d1, d2;
    idle(); rst = 1; out_ready = 1;
    @(negedge clk);

    //           rst wr b1 t1 v1 v2 dest cv ct cd rdy chk stall ov a b dest
    vt.push_back(mkv(1,0,0,0,0,0,0, 0,0,0, 1,0, 0,0,0,0,0));
    vt.push_back(mkv(1,0,0,0,0,0,0, 0,0,0, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,1,0,0,5,7,2, 0,0,0, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,1,5,7,2));
    vt.push_back(mkv(0,1,1,3,0,1,3, 1,3,32'h55, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,1,32'h55,1,3));
    vt.push_back(mkv(0,1,1,5,0,2,4, 0,0,0, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 1,5,32'h66, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,1,32'h66,2,4));
    vt.push_back(mkv(0,1,1,7,0,20,0, 0,0,0, 0,1, 0,0,0,0,0));
    vt.push_back(mkv(0,1,1,7,0,21,1, 0,0,0, 0,1, 0,0,0,0,0));
    vt.push_back(mkv(0,1,1,7,0,22,2, 0,0,0, 0,1, 0,0,0,0,0));
    vt.push_back(mkv(0,1,1,7,0,23,3, 0,0,0, 0,1, 0,0,0,0,0));
    vt.push_back(mkv(0,1,0,0,0,99,5, 0,0,0, 0,1, 1,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 1,7,32'h77, 1,1, 1,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 1,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,1,32'h77,20,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,1,32'h77,21,1));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,1,32'h77,22,2));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,1,32'h77,23,3));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,1,0,0,1,2,6, 0,0,0, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,0,0,0,0));
    vt.push_back(mkv(1,0,0,0,0,0,0, 0,0,0, 0,1, 0,1,1,2,6));
    vt.push_back(mkv(0,0,0,0,0,0,0, 0,0,0, 1,1, 0,0,0,0,0));

    foreach (vt[k]) begin
      idle();
      rst = vt[k].rst; out_ready = vt[k].rdy;
      if (vt[k].wr) wr(4'h1, vt[k].b1, vt[k].t1, vt[k].v1, vt[k].v2, vt[k].dest);
      if (vt[k].cv) cdb(vt[k].ct, vt[k].cd);
      #1;
      if (vt[k].chk) begin
        chk($sformatf("vec%0d_stall", k), alu_stall, vt[k].e_stall);
        chk($sformatf("vec%0d_valid", k), out_valid, vt[k].e_ov);
        if (vt[k].e_ov) begin
          chk($sformatf("vec%0d_op", k), out_op, 1);
          chk($sformatf("vec%0d_a", k), out_a, vt[k].e_a);
          chk($sformatf("vec%0d_b", k), out_b, vt[k].e_b);
          chk($sformatf("vec%0d_dest", k), out_dest, vt[k].e_dest);
        end
      end
      tick();
    end

    // Hold while the ALU stalls; a waiting entry still captures the CDB.
    do_reset(); out_ready = 0;
    wr(4'h2, 0, 0, 3, 4, 1); tick();
    idle(); wr(4'h3, 1, 2, 0, 8, 5); tick();
    for (int c = 0; c < 3; c++) begin
      idle();
      if (c == 1) cdb(2, 32'h99);
      chk_out($sformatf("hold%0d", c), 4'h2, 3, 4, 1);
      tick();
    end
    idle(); out_ready = 1;
    chk_out("hold_release", 4'h2, 3, 4, 1);
    tick();
    chk_out("hold_woken", 4'h3, 32'h99, 8, 5);
    tick();
    chk("hold_drained", out_valid, 0);

    // Issue order: entry 2 older than entry 0, both ready together.
    do_reset(); out_ready = 0;
    wr(1, 1, 1, 0, 0, 1); tick();
    idle(); wr(1, 1, 2, 0, 0, 2); tick();
    idle(); wr(1, 1, 3, 0, 0, 3); tick();
    idle(); cdb(1, 32'h11); tick();
    idle(); tick();
    chk("ord_first_dest", out_dest, 1);
    wr(1, 0, 0, 32'h40, 0, 4); cdb(3, 32'h33); tick();
    idle(); out_ready = 1;
    chk("ord_stall", alu_stall, 0);
    tick();
    d1 = OLDEST ? 3'd3 : 3'd4;
    d2 = OLDEST ? 3'd4 : 3'd3;
    chk("ord_sel1_valid", out_valid, 1);
    chk("ord_sel1_dest", out_dest, d1);
    tick();
    chk("ord_sel2_valid", out_valid, 1);
    chk("ord_sel2_dest", out_dest, d2);
    tick();
    chk("ord_done", out_valid, 0);

    // Flush beats a simultaneous write and CDB.
    do_reset(); out_ready = 0;
    wr(1, 0, 0, 9, 9, 1); tick();
    idle(); wr(1, 1, 7, 0, 0, 2); tick();
    idle(); wr(1, 1, 7, 0, 0, 3); tick();
    idle(); wr(1, 1, 7, 0, 0, 4); tick();
    idle();
    chk("fl_pre_valid", out_valid, 1);
    chk("fl_pre_stall", alu_stall, 0);
    flush = 1; wr(1, 0, 0, 5, 5, 5); cdb(7, 32'h70); tick();
    idle(); out_ready = 1;
    chk("fl_valid", out_valid, 0);
    chk("fl_stall", alu_stall, 0);
    chk("fl_op", out_op, 0);
    chk("fl_dest", out_dest, 0);
    tick(); tick();
    chk("fl_squashed", out_valid, 0);

    // Randomized run against the reference model.
    idle(); rst = 1; out_ready = 1;
    model_step(); tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 255) == 0);
      flush = ($urandom_range(0, 127) == 0);
      alu_write = $urandom_range(0, 1);
      in_op = 4'($urandom);
      in_q1_busy = ($urandom_range(0, 2) == 0); in_q1_tag = 3'($urandom); in_v1 = $urandom;
      in_q2_busy = ($urandom_range(0, 2) == 0); in_q2_tag = 3'($urandom); in_v2 = $urandom;
      in_dest = 3'($urandom);
      cdb_valid = ($urandom_range(0, 4) < 2); cdb_tag = 3'($urandom); cdb_data = $urandom;
      out_ready = ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      #1;
      chk("rnd_stall", alu_stall, m_full());
      chk("rnd_valid", out_valid, m_ov);
      chk("rnd_op", out_op, m_op);
      chk("rnd_a", out_a, m_a);
      chk("rnd_b", out_b, m_b);
      chk("rnd_dest", out_dest, m_dest);
      model_step();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
